prefetch_issue_queue: RTL and testbench

- Downstream consumer of the 3D spatial prefetcher. Captures the prefetcher's address stream (one address per valid pulse, no backpressure) into a small FIFO.
- Discards duplicates of recently accepted addresses.
- Issues surviving addresses to the memory/NAND request port over a valid/ready handshake.
- Counts dropped and filtered requests for performance monitoring.

---
 rtl/prefetch_issue_queue.sv | 160 ++++++++++++++++
 tb/tb_prefetch_issue_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: captures prefetcher addresses into a show-ahead FIFO,
// optionally filters recent duplicates, and issues them over valid/ready.
// Optional feature macro: PF_DUP_FILTER_EN (duplicate filter + history).
module prefetch_issue_queue #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned HIST_ENTRIES = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      pf_valid_i,
  input  logic [ADDR_WIDTH-1:0]     pf_address_i,
  input  logic                      flush_i,
  output logic                      mem_req_valid_o,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr_o,
  input  logic                      mem_req_ready_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    occupancy_o,
  output logic [15:0]               drop_count_o,
  output logic [15:0]               filtered_count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FULL} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]        occ_d;
  logic                    valid_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    pop_c, push_c, drop_c, dup_c, in_c;

  assign pop_c  = mem_req_valid_o && mem_req_ready_i;
  assign in_c   = pf_valid_i && !flush_i && !dup_c;
  assign push_c = in_c && (!full_o || pop_c);
  assign drop_c = in_c && full_o && !pop_c;

`ifdef PF_DUP_FILTER_EN
  localparam int unsigned HP_W = (HIST_ENTRIES > 1) ? $clog2(HIST_ENTRIES) : 1;

  logic [ADDR_WIDTH-1:0]   hist_q [HIST_ENTRIES];
  logic [HIST_ENTRIES-1:0] hist_vld_q;
  logic [HP_W-1:0]         hist_ptr_q;

  // Match incoming address against every valid history entry
  always_comb begin
    dup_c = 1'b0;
    for (int unsigned i = 0; i < HIST_ENTRIES; i++) begin
      if (hist_vld_q[i] && (hist_q[i] == pf_address_i)) dup_c = 1'b1;
    end
  end

  // Round-robin history of accepted addresses; flush invalidates all entries
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_vld_q <= '0;
      hist_ptr_q <= '0;
      for (int unsigned i = 0; i < HIST_ENTRIES; i++) hist_q[i] <= '0;
    end else if (flush_i) begin
      hist_vld_q <= '0;
      hist_ptr_q <= '0;
    end else if (push_c) begin
      hist_q[hist_ptr_q]     <= pf_address_i;
      hist_vld_q[hist_ptr_q] <= 1'b1;
      hist_ptr_q <= (hist_ptr_q == HP_W'(HIST_ENTRIES - 1)) ? '0 : hist_ptr_q + HP_W'(1);
    end
  end

  // Saturating duplicate counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filtered_count_o <= '0;
    end else if (pf_valid_i && !flush_i && dup_c && (filtered_count_o != 16'hFFFF)) begin
      filtered_count_o <= filtered_count_o + 16'd1;
    end
  end
`else
  logic [31:0] unused_hist_entries;
  assign unused_hist_entries = 32'(HIST_ENTRIES);
  assign dup_c               = 1'b0;
  assign filtered_count_o    = '0;
`endif

  // FIFO storage write at tail
  always_ff @(posedge clock) begin
    if (push_c) mem_q[wr_ptr_q] <= pf_address_i;
  end

  // Next-state: queue FSM, pointers, occupancy and show-ahead head register
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occupancy_o;
    valid_d  = mem_req_valid_o;
    addr_d   = mem_req_addr_o;
    if (flush_i) begin
      state_d  = ST_IDLE;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
      valid_d  = 1'b0;
    end else begin
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      occ_d = occupancy_o + OCC_W'(1);
      else if (pop_c && !push_c) occ_d = occupancy_o - OCC_W'(1);
      case (state_q)
        ST_IDLE:   if (push_c) state_d = ST_ACTIVE;
        ST_ACTIVE: begin
          if (push_c && !pop_c && (occupancy_o == OCC_W'(DEPTH - 1)))  state_d = ST_FULL;
          else if (pop_c && !push_c && (occupancy_o == OCC_W'(1)))     state_d = ST_IDLE;
        end
        ST_FULL:   if (pop_c && !push_c) state_d = ST_ACTIVE;
        default:   state_d = ST_IDLE;
      endcase
      valid_d = (occ_d != '0);
      // A push into an otherwise-empty queue becomes the head directly
      if (push_c && (rd_ptr_d == wr_ptr_q)) addr_d = pf_address_i;
      else if (occ_d != '0)                 addr_d = mem_q[rd_ptr_d];
    end
  end

  // Queue state, pointers and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      occupancy_o     <= '0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      full_o          <= 1'b0;
      empty_o         <= 1'b1;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      occupancy_o     <= occ_d;
      mem_req_valid_o <= valid_d;
      mem_req_addr_o  <= addr_d;
      full_o          <= (state_d == ST_FULL);
      empty_o         <= (state_d == ST_IDLE);
    end
  end

  // Saturating drop counter; flush-cycle inputs are never counted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count_o <= '0;
    end else if (drop_c && (drop_count_o != 16'hFFFF)) begin
      drop_count_o <= drop_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Self-checking bench for prefetch_issue_queue: queue-based reference model
// compared every cycle, directed scenarios with literal expectations, random
// traffic and counter saturation.
module tb_prefetch_issue_queue;

  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned DEPTH        = 8;
  localparam int unsigned HIST_ENTRIES = 4;

  logic        clock, reset_n;
  logic        pf_valid_i, flush_i, mem_req_ready_i;
  logic [31:0] pf_address_i;
  logic        mem_req_valid_o, full_o, empty_o;
  logic [31:0] mem_req_addr_o;
  logic [3:0]  occupancy_o;
  logic [15:0] drop_count_o, filtered_count_o;

  prefetch_issue_queue #(
    .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .HIST_ENTRIES(HIST_ENTRIES)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .pf_valid_i(pf_valid_i), .pf_address_i(pf_address_i), .flush_i(flush_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_ready_i(mem_req_ready_i),
    .full_o(full_o), .empty_o(empty_o), .occupancy_o(occupancy_o),
    .drop_count_o(drop_count_o), .filtered_count_o(filtered_count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_q[$];
  logic [31:0] hist_q[$];
  int          m_drop = 0;
  int          m_filt = 0;

`ifdef PF_DUP_FILTER_EN
  localparam int FILT_EN = 1;
`else
  localparam int FILT_EN = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: queue of accepted addresses plus list of the most recent accepts
  task automatic model_edge(input logic v, input logic [31:0] a, input logic r, input logic f);
    logic dup;
    if (f) begin
      model_q.delete();
      hist_q.delete();
    end else begin
      if (r && model_q.size() != 0) void'(model_q.pop_front());
      if (v) begin
        dup = 1'b0;
        if (FILT_EN != 0) foreach (hist_q[i]) if (hist_q[i] == a) dup = 1'b1;
        if (dup) begin
          if (m_filt < 16'hFFFF) m_filt++;
        end else if (model_q.size() == DEPTH) begin
          if (m_drop < 16'hFFFF) m_drop++;
        end else begin
          model_q.push_back(a);
          hist_q.push_back(a);
          if (hist_q.size() > HIST_ENTRIES) void'(hist_q.pop_front());
        end
      end
    end
  endtask

  task automatic check_all();
    chk("occupancy", 32'(occupancy_o), 32'(model_q.size()));
    chk("full", 32'(full_o), 32'(model_q.size() == DEPTH));
    chk("empty", 32'(empty_o), 32'(model_q.size() == 0));
    chk("valid", 32'(mem_req_valid_o), 32'(model_q.size() != 0));
    if (model_q.size() != 0) chk("addr", mem_req_addr_o, model_q[0]);
    chk("drop_count", 32'(drop_count_o), 32'(m_drop));
    chk("filtered_count", 32'(filtered_count_o), 32'(m_filt));
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic r, input logic f);
    pf_valid_i = v; pf_address_i = a; mem_req_ready_i = r; flush_i = f;
    @(posedge clock);
    model_edge(v, a, r, f);
    #1;
    check_all();
  endtask

  initial begin
    reset_n = 1'b0;
    pf_valid_i = 1'b0; pf_address_i = '0; mem_req_ready_i = 1'b0; flush_i = 1'b0;
    #12;
    chk("rst_addr", mem_req_addr_o, 32'h0);
    chk("rst_empty", 32'(empty_o), 32'h1);
    check_all();
    reset_n = 1'b1;

    // In-order issue with ready held high
    step(1'b1, 32'h05, 1'b1, 1'b0); chk("t1_a0", mem_req_addr_o, 32'h05);
    step(1'b1, 32'h07, 1'b1, 1'b0); chk("t1_a1", mem_req_addr_o, 32'h07);
    step(1'b1, 32'h0B, 1'b1, 1'b0); chk("t1_a2", mem_req_addr_o, 32'h0B);
    step(1'b0, 32'h00, 1'b1, 1'b0); chk("t1_empty", 32'(mem_req_valid_o), 32'h0);

    // Repeated address
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0D, 1'b0, 1'b0);
    chk("t2_occ", 32'(occupancy_o), (FILT_EN != 0) ? 32'd1 : 32'd3);
    chk("t2_filt", 32'(filtered_count_o), (FILT_EN != 0) ? 32'd2 : 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Overfill
    for (int i = 0; i < 10; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    chk("t3_full", 32'(full_o), 32'h1);
    chk("t3_drop", 32'(drop_count_o), 32'd2);
    chk("t3_head", mem_req_addr_o, 32'h100);

    // Push and pop together while full
    step(1'b1, 32'h200, 1'b1, 1'b0);
    chk("t4_occ", 32'(occupancy_o), 32'd8);
    chk("t4_head", mem_req_addr_o, 32'h101);
    chk("t4_drop", 32'(drop_count_o), 32'd2);

    // Flush with same-cycle push and handshake
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t5_occ3", 32'(occupancy_o), 32'd3);
    step(1'b1, 32'h300, 1'b1, 1'b1);
    chk("t5_empty", 32'(empty_o), 32'h1);
    chk("t5_valid", 32'(mem_req_valid_o), 32'h0);
    step(1'b1, 32'h107, 1'b0, 1'b0);
    chk("t5_repush", mem_req_addr_o, 32'h107);
    chk("t5_occ", 32'(occupancy_o), 32'd1);
    chk("t5_drop", 32'(drop_count_o), 32'd2);

    // Asynchronous reset mid-stream
    step(1'b1, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h401, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    model_q.delete(); hist_q.delete(); m_drop = 0; m_filt = 0;
    chk("t6_rst_addr", mem_req_addr_o, 32'h0);
    check_all();
    @(posedge clock);
    #2 reset_n = 1'b1;
    step(1'b1, 32'h55, 1'b0, 1'b0);
    chk("t6_first", mem_req_addr_o, 32'h55);
    chk("t6_valid", 32'(mem_req_valid_o), 32'h1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 60, 32'($urandom_range(0, 11)),
           $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2);
    end

    // Drop counter saturation
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 65545 + DEPTH; i++) step(1'b1, 32'h10000 + 32'(i), 1'b0, 1'b0);
    chk("sat_drop", 32'(drop_count_o), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
